// File: rtl/ledanimator.sv
// LED animation engine: bounce / chase / fill / direct owner patterns, each LED
// fading out by halving its duty per step, rendered through bit-reversed PWM.

module ledanimator_lane #(
   parameter int PWMBITS = 5
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_step,
   input  logic               i_own,
   input  logic [PWMBITS-1:0] i_brev,
   output logic               o_led
);
   localparam logic [PWMBITS-1:0] MAX = '1;

   logic [PWMBITS-1:0] duty_q, duty_d;
   logic               led_q, led_d;

   always_comb begin
      duty_d = duty_q;
      if (i_step) duty_d = i_own ? MAX : (duty_q >> 1);
   end

   // Comparing against the bit-reversed counter spreads on-time over the period.
   assign led_d = (duty_q == MAX) | ((duty_q != '0) & (i_brev < duty_q));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         duty_q <= '0;
         led_q  <= 1'b0;
      end else begin
         duty_q <= duty_d;
         led_q  <= led_d;
      end
   end

   assign o_led = led_q;
endmodule

module ledanimator #(
   parameter int NLEDS   = 8,
   parameter int PWMBITS = 5,
   parameter int CTRBITS = 25
) (
   input  logic                         i_clk,
   input  logic                         i_reset_n,
   input  logic [1:0]                   i_mode,
   input  logic [CTRBITS-1:0]           i_period,
   input  logic                         i_pause,
   input  logic [NLEDS-1:0]             i_direct,
   output logic [NLEDS-1:0]             o_leds,
   output logic                         o_step,
   output logic [$clog2(NLEDS+1)-1:0]   o_pos
);
   localparam int POSW = $clog2(NLEDS+1);

   localparam logic [1:0] M_BOUNCE = 2'd0;
   localparam logic [1:0] M_CHASE  = 2'd1;
   localparam logic [1:0] M_FILL   = 2'd2;
   localparam logic [1:0] M_DIRECT = 2'd3;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   localparam logic [NLEDS-1:0] LED0 = NLEDS'(1);

   logic [CTRBITS-1:0] ctr_q, ctr_d;
   logic               step;
   logic [PWMBITS-1:0] pwm_q, brev;
   logic [1:0]         mode_q, mode_d;
   logic [NLEDS-1:0]   owner_q, owner_d, own_mask;
   logic               dir_q, dir_d;
   logic [POSW-1:0]    fill_q, fill_d;
   logic [POSW-1:0]    pos_q, pos_d;
   logic               step_q;
   logic [NLEDS-1:0]   leds;

   function automatic logic [POSW-1:0] onehot_idx(input logic [NLEDS-1:0] v);
      logic [POSW-1:0] r;
      r = '0;
      for (int k = NLEDS-1; k >= 0; k--)
         if (v[k]) r = POSW'(k);
      return r;
   endfunction

   function automatic logic [NLEDS-1:0] fill_mask(input logic [POSW-1:0] f);
      logic [NLEDS-1:0] m;
      m = '0;
      for (int k = 0; k < NLEDS; k++)
         m[k] = (POSW'(k) < f);
      return m;
   endfunction

   // Prescaler: a period lowered below the running count fires on the next clock.
   assign step = !i_pause && (ctr_q >= i_period);

   always_comb begin
      ctr_d = ctr_q;
      if (!i_pause) ctr_d = step ? '0 : ctr_q + CTRBITS'(1);
   end

   for (genvar b = 0; b < PWMBITS; b++) begin : g_brev
      assign brev[b] = pwm_q[PWMBITS-1-b];
   end

   always_comb begin
      mode_d   = mode_q;
      owner_d  = owner_q;
      dir_d    = dir_q;
      fill_d   = fill_q;
      pos_d    = pos_q;
      own_mask = '0;
      if (step) begin
         if (i_mode != mode_q) begin
            // Mode switch costs one step: pattern restarts, everything just fades.
            mode_d  = i_mode;
            owner_d = LED0;
            dir_d   = DIR_UP;
            fill_d  = '0;
         end else begin
            case (mode_q)
               M_BOUNCE: begin
                  if (owner_q == '0) begin
                     owner_d = LED0;
                     dir_d   = DIR_UP;
                  end else if (dir_q == DIR_UP) begin
                     if (owner_q[NLEDS-1]) dir_d = DIR_DN;
                     else                  owner_d = owner_q << 1;
                  end else begin
                     if (owner_q[0]) dir_d = DIR_UP;
                     else            owner_d = owner_q >> 1;
                  end
                  own_mask = owner_d;
               end
               M_CHASE: begin
                  if (owner_q == '0) begin
                     owner_d = LED0;
                     dir_d   = DIR_UP;
                  end else begin
                     owner_d = {owner_q[NLEDS-2:0], owner_q[NLEDS-1]};
                  end
                  own_mask = owner_d;
               end
               M_FILL: begin
                  if (dir_q == DIR_UP) begin
                     if (fill_q >= POSW'(NLEDS)) dir_d = DIR_DN;
                     else                        fill_d = fill_q + POSW'(1);
                  end else begin
                     if (fill_q == '0) dir_d = DIR_UP;
                     else              fill_d = fill_q - POSW'(1);
                  end
                  own_mask = fill_mask(fill_d);
               end
               default: own_mask = i_direct;
            endcase
         end
         case (mode_d)
            M_BOUNCE, M_CHASE: pos_d = onehot_idx(owner_d);
            M_FILL:            pos_d = fill_d;
            default:           pos_d = '0;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ctr_q   <= '0;
         pwm_q   <= '0;
         mode_q  <= M_BOUNCE;
         owner_q <= LED0;
         dir_q   <= DIR_UP;
         fill_q  <= '0;
         pos_q   <= '0;
         step_q  <= 1'b0;
      end else begin
         ctr_q   <= ctr_d;
         pwm_q   <= pwm_q + PWMBITS'(1);
         mode_q  <= mode_d;
         owner_q <= owner_d;
         dir_q   <= dir_d;
         fill_q  <= fill_d;
         pos_q   <= pos_d;
         step_q  <= step;
      end
   end

   for (genvar k = 0; k < NLEDS; k++) begin : g_lane
      ledanimator_lane #(.PWMBITS(PWMBITS)) u_lane (
         .i_clk     (i_clk),
         .i_reset_n (i_reset_n),
         .i_step    (step),
         .i_own     (own_mask[k]),
         .i_brev    (brev),
         .o_led     (leds[k])
      );
   end

   assign o_leds = leds;
   assign o_step = step_q;
   assign o_pos  = pos_q;
endmodule

// File: tb/tb_ledanimator.sv
// Bench for ledanimator: integer-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.

module tb_ledanimator;
   localparam int N    = 8;
   localparam int PB   = 5;
   localparam int CB   = 25;
   localparam int PW   = $clog2(N+1);
   localparam int MAXD = (1 << PB) - 1;

   logic          i_clk     = 1'b0;
   logic          i_reset_n = 1'b0;
   logic [1:0]    i_mode    = 2'd0;
   logic [CB-1:0] i_period  = CB'(3);
   logic          i_pause   = 1'b0;
   logic [N-1:0]  i_direct  = '0;
   logic [N-1:0]  o_leds;
   logic          o_step;
   logic [PW-1:0] o_pos;

   always #5 i_clk = ~i_clk;

   ledanimator #(.NLEDS(N), .PWMBITS(PB), .CTRBITS(CB)) dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_mode    (i_mode),
      .i_period  (i_period),
      .i_pause   (i_pause),
      .i_direct  (i_direct),
      .o_leds    (o_leds),
      .o_step    (o_step),
      .o_pos     (o_pos)
   );

   int checks = 0;
   int errors = 0;

   // Reference state: LED position as an integer, duties as plain numbers.
   int           m_ctr = 0, m_pwm = 0, m_mode = 0, m_pos = 0, m_up = 1, m_fill = 0;
   int           m_duty [N] = '{default: 0};
   int           m_b, e_pos = 0;
   bit           m_stp, e_step = 1'b0;
   logic [N-1:0] m_own, e_leds = '0;

   int bexp [17] = '{1,2,3,4,5,6,7,7,6,5,4,3,2,1,0,0,1};
   int fexp [18] = '{1,2,3,4,5,6,7,8,8,7,6,5,4,3,2,1,0,0};

   initial forever begin
      @(posedge i_clk or negedge i_reset_n);
      if (!i_reset_n) begin
         m_ctr = 0; m_pwm = 0; m_mode = 0; m_pos = 0; m_up = 1; m_fill = 0;
         for (int k = 0; k < N; k++) m_duty[k] = 0;
         e_step = 1'b0; e_pos = 0; e_leds = '0;
      end else begin
         m_b = 0;
         for (int i = 0; i < PB; i++)
            if (((m_pwm >> i) & 1) != 0) m_b += 1 << (PB-1-i);
         for (int k = 0; k < N; k++)
            e_leds[k] = (m_duty[k] == MAXD) || (m_duty[k] > 0 && m_b < m_duty[k]);
         m_pwm  = (m_pwm + 1) % (1 << PB);
         m_stp  = !i_pause && (m_ctr >= int'(i_period));
         e_step = m_stp;
         if (!i_pause) m_ctr = m_stp ? 0 : m_ctr + 1;
         if (m_stp) begin
            m_own = '0;
            if (int'(i_mode) != m_mode) begin
               m_mode = int'(i_mode); m_pos = 0; m_up = 1; m_fill = 0;
            end else begin
               case (m_mode)
                  0: begin
                     if (m_up != 0) begin
                        if (m_pos == N-1) m_up = 0; else m_pos++;
                     end else begin
                        if (m_pos == 0) m_up = 1; else m_pos--;
                     end
                     m_own[m_pos] = 1'b1;
                  end
                  1: begin
                     m_pos = (m_pos + 1) % N;
                     m_own[m_pos] = 1'b1;
                  end
                  2: begin
                     if (m_up != 0) begin
                        if (m_fill == N) m_up = 0; else m_fill++;
                     end else begin
                        if (m_fill == 0) m_up = 1; else m_fill--;
                     end
                     for (int k = 0; k < N; k++) m_own[k] = (k < m_fill);
                  end
                  default: m_own = i_direct;
               endcase
            end
            for (int k = 0; k < N; k++)
               m_duty[k] = m_own[k] ? MAXD : m_duty[k] / 2;
            e_pos = (m_mode == 2) ? m_fill : (m_mode == 3) ? 0 : m_pos;
         end
      end
   end

   initial forever begin
      @(posedge i_clk);
      #1;
      checks++;
      if (o_step !== e_step) begin
         errors++;
         $display("FAIL model_step t=%0t got %b expected %b", $time, o_step, e_step);
      end
      checks++;
      if (o_pos !== PW'(e_pos)) begin
         errors++;
         $display("FAIL model_pos t=%0t got %0d expected %0d", $time, o_pos, e_pos);
      end
      checks++;
      if (o_leds !== e_leds) begin
         errors++;
         $display("FAIL model_leds t=%0t got %b expected %b", $time, o_leds, e_leds);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic wait_step(input int bound, output bit ok);
      int n;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < bound) begin
         @(posedge i_clk);
         #1;
         n++;
         if (o_step === 1'b1) ok = 1'b1;
      end
   endtask

   initial begin
      int  n, cnt, viol, prev;
      bit  ok;

      // Reset values and first-step latency with i_period=3.
      repeat (3) @(negedge i_clk);
      chk("reset_leds", int'(o_leds), 0);
      chk("reset_pos", int'(o_pos), 0);
      chk("reset_step", int'(o_step), 0);
      i_reset_n = 1'b1;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 12) begin
         @(posedge i_clk);
         #1;
         n++;
         if (o_step === 1'b1) ok = 1'b1;
      end
      chk("first_step_latency", ok ? n : -1, 4);
      chk("first_step_pos", int'(o_pos), 1);
      #2 i_reset_n = 1'b0;
      #1;
      chk("midreset_step", int'(o_step), 0);
      chk("midreset_pos", int'(o_pos), 0);
      chk("midreset_leds", int'(o_leds), 0);

      // BOUNCE at one step per clock.
      @(negedge i_clk) i_period = '0;
      @(negedge i_clk) i_reset_n = 1'b1;
      for (int i = 0; i < 17; i++) begin
         @(posedge i_clk);
         #1;
         chk("bounce_pos", int'(o_pos), bexp[i]);
         if (i > 0) chk("bounce_owner_lit", int'(o_leds[bexp[i-1]]), 1);
      end

      // CHASE wraps 7 -> 0.
      @(negedge i_clk) i_mode = 2'd1;
      @(posedge i_clk);
      #1 chk("chase_switch_pos", int'(o_pos), 0);
      for (int i = 1; i <= 9; i++) begin
         @(posedge i_clk);
         #1 chk("chase_pos", int'(o_pos), i % N);
      end

      // FILL up and down with dwell at both ends.
      @(negedge i_clk) i_mode = 2'd2;
      @(posedge i_clk);
      #1 chk("fill_switch_pos", int'(o_pos), 0);
      for (int i = 0; i < 18; i++) begin
         @(posedge i_clk);
         #1 chk("fill_pos", int'(o_pos), fexp[i]);
         if (i == 8) chk("fill_full_leds", int'(o_leds), 255);
      end

      // DIRECT: solid pattern, then fade with a duty-15 PWM window.
      @(negedge i_clk);
      i_mode   = 2'd3;
      i_direct = 8'hA5;
      repeat (8) @(posedge i_clk);
      #1;
      chk("direct_solid", int'(o_leds), 'hA5);
      chk("direct_pos", int'(o_pos), 0);
      @(negedge i_clk);
      i_direct = '0;
      i_period = CB'(31);
      wait_step(40, ok);
      chk("direct_fade_step_seen", int'(ok), 1);
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         @(posedge i_clk);
         #1 if (o_leds[0] === 1'b1) cnt++;
      end
      chk("duty15_lit_count", cnt, 15);
      @(negedge i_clk) i_period = '0;
      repeat (6) @(posedge i_clk);
      #1 chk("direct_dark", int'(o_leds), 0);

      // Pause freezes steps and position; queued mode change lands afterwards.
      @(negedge i_clk);
      i_mode   = 2'd0;
      i_period = CB'(2);
      repeat (20) @(negedge i_clk);
      i_pause = 1'b1;
      i_mode  = 2'd1;
      prev    = int'(o_pos);
      viol    = 0;
      repeat (100) begin
         @(posedge i_clk);
         #1 if (o_step !== 1'b0 || int'(o_pos) != prev) viol++;
      end
      chk("pause_frozen", viol, 0);
      @(negedge i_clk) i_pause = 1'b0;
      wait_step(10, ok);
      chk("pause_release_step_seen", int'(ok), 1);
      chk("pause_mode_switch_pos", int'(o_pos), 0);

      // Randomized traffic against the model.
      repeat (3000) begin
         @(negedge i_clk);
         if ($urandom_range(0, 49) == 0) i_mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) i_period = CB'($urandom_range(0, 6));
         i_pause  = ($urandom_range(0, 9) == 0);
         i_direct = N'($urandom);
         if ($urandom_range(0, 999) == 0) begin
            i_reset_n = 1'b0;
            #2 i_reset_n = 1'b1;
         end
      end

      @(negedge i_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
